// File: rtl/fsa_pkg.sv
// Constants and state encoding shared by the FIR, frame controller and FFT
// blocks of the frequency-analysis chain.
package fsa_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  localparam int FSA_DW        = 16;
  localparam int FSA_FRAME_LEN = 16;
  localparam int FSA_FIR_LAT   = 33;
endpackage

// File: rtl/fir_frame_buf.sv
// Two-bank frame RAM: one write port and one registered read port.
// The bank index is the MSB of the flat address.
module fir_frame_buf #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 16,
  parameter int AW        = $clog2(FRAME_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  logic [DW-1:0] mem_q [2*FRAME_LEN];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
  end

  // Read register is reset so the output port reads 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fir_frame_ctrl.sv
// Gates samples into the FIR, skips its pipeline-fill outputs and packs valid
// outputs into frames held in a ping-pong buffer read by the FFT.
module fir_frame_ctrl
  import fsa_pkg::*;
#(
  parameter int DW        = FSA_DW,
  parameter int FRAME_LEN = FSA_FRAME_LEN,
  parameter int FIR_LAT   = FSA_FIR_LAT,
  parameter int CNT_W     = 8,
  localparam int AW       = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             src_valid,
  input  logic [DW-1:0]    src_data,
  output logic             src_ready,
  output logic             fir_data_valid,
  output logic [DW-1:0]    fir_data,
  input  logic [DW-1:0]    fir_d,
  output logic             frame_rdy,
  output logic             frame_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  input  logic             frame_done,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int FC_W = $clog2(FIR_LAT + 1);

  state_e           state_q;
  logic             fdv_q;
  logic [DW-1:0]    fir_data_q;
  logic [FC_W-1:0]  fill_cnt_q;
  logic [AW-1:0]    wr_ptr_q;
  logic             skip_q;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, rd_bank_q;
  logic             ovf_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic capture, frame_first, drop, we, commit, rel_bank;

  // A frame's drop decision is made once, at its first sample, and held in skip_q.
  assign capture     = (state_q == RUN) && fdv_q && !stop;
  assign frame_first = (wr_ptr_q == '0);
  assign drop        = frame_first ? bank_full_q[wr_bank_q] : skip_q;
  assign we          = capture && !drop;
  assign commit      = we && (wr_ptr_q == AW'(FRAME_LEN - 1));
  assign rel_bank    = frame_done && bank_full_q[rd_bank_q];

  always_comb begin
    bank_full_d = bank_full_q;
    if (rel_bank) bank_full_d[rd_bank_q] = 1'b0;
    if (commit)   bank_full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fdv_q       <= 1'b0;
      fir_data_q  <= '0;
      fill_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      skip_q      <= 1'b0;
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      fdv_q       <= (state_q != IDLE) && src_valid && !stop;
      fir_data_q  <= src_data;
      bank_full_q <= bank_full_d;
      if (rel_bank) rd_bank_q <= ~rd_bank_q;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FILL;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            fill_cnt_q  <= '0;
            wr_ptr_q    <= '0;
          end
        end
        default: begin
          if (stop) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
          end else if (!fdv_q) begin
            // The FIR has cleared its accumulators: refill and drop the partial frame.
            state_q    <= FILL;
            fill_cnt_q <= '0;
            wr_ptr_q   <= '0;
          end else if (state_q == FILL) begin
            if (fill_cnt_q == FC_W'(FIR_LAT - 1)) begin
              state_q    <= RUN;
              fill_cnt_q <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + FC_W'(1);
            end
          end else begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (frame_first) begin
              skip_q <= drop;
              if (drop) ovf_q <= 1'b1;
            end
            if (commit) begin
              wr_bank_q   <= ~wr_bank_q;
              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  fir_frame_buf #(
    .DW        (DW),
    .FRAME_LEN (FRAME_LEN),
    .AW        (AW)
  ) u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (we),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fir_d),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign busy           = (state_q != IDLE);
  assign src_ready      = (state_q != IDLE);
  assign fir_data_valid = fdv_q;
  assign fir_data       = fir_data_q;
  assign frame_rdy      = bank_full_q[rd_bank_q];
  assign frame_bank     = rd_bank_q;
  assign ovf            = ovf_q;
  assign frame_cnt      = frame_cnt_q;
endmodule
